// File: rtl/ppu_pkg.sv
// Shared PPU definitions: FIR width derivations, decoder FSM states and the FIR field layout.
package ppu_pkg;

    localparam int PPU_N  = 16;
    localparam int PPU_ES = 1;

    function automatic int k_size(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int te_size(input int n, input int es);
        return k_size(n) + es;
    endfunction

    function automatic int frac_size(input int n, input int es);
        return n - 3 - es;
    endfunction

    function automatic int fir_total_size(input int n, input int es);
        return 1 + te_size(n, es) + frac_size(n, es);
    endfunction

    localparam int PPU_K_SIZE         = k_size(PPU_N);
    localparam int PPU_TE_SIZE        = te_size(PPU_N, PPU_ES);
    localparam int PPU_FRAC_SIZE      = frac_size(PPU_N, PPU_ES);
    localparam int PPU_FIR_TOTAL_SIZE = fir_total_size(PPU_N, PPU_ES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIR layout for the default PPU configuration (MSB first).
    typedef struct packed {
        logic                     sign;
        logic [PPU_TE_SIZE-1:0]   te;
        logic [PPU_FRAC_SIZE-1:0] frac;
    } fir_t;

endpackage

// File: rtl/posit_to_fir_seq_regime_scanner.sv
// Regime run-length scanner: consumes one regime bit per cycle and strobes done
// in the cycle the last run bit is consumed.
module regime_scanner
    import ppu_pkg::*;
#(
    parameter  int N      = 16,
    localparam int K_SIZE = k_size(N),
    localparam int CW     = K_SIZE - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [N-2:0]      load_bits,
    input  logic              run,
    output logic              done,
    output logic              r0,
    output logic [K_SIZE-1:0] run_len,
    output logic [N-4:0]      tail
);

    localparam logic [CW-1:0] LAST = CW'(N - 2);

    // sr holds the bits following the run bit being consumed; sr MSB is the
    // next bit, so the terminator is seen one cycle early and dropped for free.
    logic [N-3:0]  sr;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr    <= '0;
            count <= '0;
            r0    <= 1'b0;
        end else if (load) begin
            sr    <= load_bits[N-3:0];
            r0    <= load_bits[N-2];
            count <= '0;
        end else if (run && !done) begin
            sr    <= {sr[N-4:0], 1'b0};
            count <= count + CW'(1);
        end
    end

    assign done    = run && ((sr[N-3] != r0) || (count == LAST));
    assign run_len = {1'b0, count} + K_SIZE'(1);
    // An exhausted regime has already shifted every real bit out, so tail is zero.
    assign tail    = sr[N-4:0];

endmodule

// File: rtl/posit_to_fir_seq.sv
// Sequential posit-to-FIR decoder with valid/ready on both sides.
// Optional PTF_SPECIAL_FLAGS_EN adds registered out_is_zero / out_is_nar outputs.
module posit_to_fir_seq
    import ppu_pkg::*;
#(
    parameter  int N              = 16,
    parameter  int ES             = 1,
    localparam int K_SIZE         = k_size(N),
    localparam int TE_SIZE        = te_size(N, ES),
    localparam int FRAC_SIZE      = frac_size(N, ES),
    localparam int FIR_TOTAL_SIZE = fir_total_size(N, ES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              in_posit,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef PTF_SPECIAL_FLAGS_EN
    output logic                      out_is_zero,
    output logic                      out_is_nar,
`endif
    output logic [FIR_TOTAL_SIZE-1:0] out_fir
);

    typedef struct packed {
        logic                 sign;
        logic [TE_SIZE-1:0]   te;
        logic [FRAC_SIZE-1:0] frac;
    } fir_fields_t;

    state_t            state;
    logic              accept;
    logic              special;
    logic              sign_q;
    logic [N-2:0]      mag;
    logic              scan_done;
    logic              r0;
    logic [K_SIZE-1:0] run_len;
    logic [K_SIZE-1:0] k;
    logic [N-4:0]      tail;
    fir_fields_t       fields;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    // Zero and NaR are the only posits with an all-zero body.
    assign special  = (in_posit[N-2:0] == '0);
    assign mag      = in_posit[N-1] ? -in_posit[N-2:0] : in_posit[N-2:0];

    regime_scanner #(.N(N)) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && !special),
        .load_bits (mag),
        .run       (state == SCAN),
        .done      (scan_done),
        .r0        (r0),
        .run_len   (run_len),
        .tail      (tail)
    );

    assign k           = r0 ? (run_len - K_SIZE'(1)) : -run_len;
    assign fields.sign = sign_q;

    // te = k*2^ES + exp is just k with the exponent bits appended.
    generate
        if (ES > 0) begin : g_exp
            assign fields.te   = {k, tail[N-4 -: ES]};
            assign fields.frac = tail[N-4-ES:0];
        end else begin : g_noexp
            assign fields.te   = k;
            assign fields.frac = tail;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_fir   <= '0;
            sign_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if ((state == DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (accept) begin
                        sign_q <= in_posit[N-1];
                        if (special) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_fir   <= {in_posit[N-1], {(FIR_TOTAL_SIZE-1){1'b0}}};
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (scan_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_fir   <= fields;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PTF_SPECIAL_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_is_zero <= 1'b0;
            out_is_nar  <= 1'b0;
        end else if (accept) begin
            out_is_zero <= special && !in_posit[N-1];
            out_is_nar  <= special && in_posit[N-1];
        end
    end
`else
    // Zero and NaR are told apart only by their out_fir encodings.
`endif

endmodule

// File: tb/tb_posit_to_fir_seq.sv
// Randomized self-checking bench for posit_to_fir_seq (N=16, ES=1) against a
// bit-walking reference decoder; also covers backpressure and mid-scan reset.
module tb_posit_to_fir_seq;
    import ppu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_posit = '0;
    logic        in_ready;
    logic        out_valid;
    logic [18:0] out_fir;
`ifdef PTF_SPECIAL_FLAGS_EN
    logic        out_is_zero;
    logic        out_is_nar;
`endif

    posit_to_fir_seq #(.N(16), .ES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_posit  (in_posit),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PTF_SPECIAL_FLAGS_EN
        .out_is_zero (out_is_zero),
        .out_is_nar  (out_is_nar),
`endif
        .out_fir   (out_fir)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    function automatic logic bit_at(input logic [15:0] v, input int j);
        return (j >= 0) ? v[j] : 1'b0;
    endfunction

    // Reference decoder: walk the regime from the top, then read exp and fraction.
    function automatic void model(input logic [15:0] p, output logic [18:0] fir, output int lat);
        fir_t        f;
        logic [15:0] mag;
        int          m, i, k, te;
        logic        r0, e;
        f = '0;
        if (p[14:0] == 15'd0) begin
            f.sign = p[15];
            fir    = f;
            lat    = 1;
            return;
        end
        mag = p[15] ? (16'd0 - p) : p;
        r0  = mag[14];
        m   = 0;
        i   = 14;
        while (i >= 0 && mag[i] == r0) begin
            m++;
            i--;
        end
        k = r0 ? m - 1 : -m;
        e = bit_at(mag, i - 1);
        for (int j = 0; j < 12; j++) f.frac[11-j] = bit_at(mag, i - 2 - j);
        te     = k * 2 + int'(e);
        f.te   = 6'(te);
        f.sign = p[15];
        fir    = f;
        lat    = 1 + m;
    endfunction

    task automatic pin(input logic [15:0] p, input logic [18:0] fir_exp, input int lat_exp);
        logic [18:0] fir;
        int          lat;
        model(p, fir, lat);
        check($sformatf("model_fir_%h", p), fir, fir_exp);
        check($sformatf("model_lat_%h", p), lat, lat_exp);
    endtask

    typedef struct {
        logic [15:0] p;
        logic [18:0] fir;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    bit          presented = 1'b0;
    logic [18:0] shown;
    bit          exp_rdy;
    exp_t        e_new;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_rdy = (q.size() == 0) || (q.size() == 1 && out_valid && out_ready);
            check("in_ready", in_ready, exp_rdy);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    if (!presented) begin
                        check($sformatf("latency_%h", q[0].p), cyc - q[0].acc, q[0].lat);
                        presented = 1'b1;
                        shown     = out_fir;
                    end else begin
                        check("fir_stable", out_fir, shown);
                    end
                    if (out_ready) begin
                        check($sformatf("fir_%h", q[0].p), out_fir, q[0].fir);
`ifdef PTF_SPECIAL_FLAGS_EN
                        check("is_zero", out_is_zero, q[0].p == 16'h0000);
                        check("is_nar", out_is_nar, q[0].p == 16'h8000);
`endif
                        void'(q.pop_front());
                        presented = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e_new.p   = in_posit;
                e_new.acc = cyc;
                model(in_posit, e_new.fir, e_new.lat);
                q.push_back(e_new);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] p);
        int t = 0;
        in_valid = 1'b1;
        in_posit = p;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) timeout("send");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_posit = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (q.size() != 0) timeout("drain");
    endtask

    logic [15:0] rp;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_fir", out_fir, 19'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        pin(16'h4000, {1'b0, 6'h00, 12'h000}, 2);
        pin(16'h4800, {1'b0, 6'h00, 12'h800}, 2);
        pin(16'hC000, {1'b1, 6'h00, 12'h000}, 2);
        pin(16'h7FFF, {1'b0, 6'h1C, 12'h000}, 16);
        pin(16'h0001, {1'b0, 6'h24, 12'h000}, 15);
        pin(16'h0000, 19'd0, 1);
        pin(16'h8000, {1'b1, 6'h00, 12'h000}, 1);
        pin(16'h5A00, {1'b0, 6'h01, 12'hA00}, 2);

        out_ready = 1'b1;
        send(16'h4000);
        send(16'h4800);
        send(16'hC000);
        send(16'h7FFF);
        send(16'h0001);
        send(16'h0000);
        send(16'h8000);
        send(16'h0000);
        send(16'h5A00);
        drain();

        // Hold the result for 5 cycles, then pop and accept in the same cycle.
        out_ready = 1'b0;
        send(16'h7FFF);
        for (int t = 0; t < 40 && !out_valid; t++) @(posedge clk);
        if (!out_valid) timeout("bp_wait");
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h4800);
        drain();

        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: rp = 16'h0000;
                1: rp = 16'h8000;
                2: rp = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h0001;
                3: rp = ($urandom_range(0, 1) != 0) ? 16'h8001 : 16'hFFFF;
                default: rp = 16'($urandom);
            endcase
            send(rp);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a long scan must leave no stale output.
        mon_en = 1'b0;
        send(16'h7FFF);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_fir", out_fir, 19'd0);
        check("midrst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale", out_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
